// File: rtl/uart_pkg.sv
// Shared UART types: receive FIFO entry layout and counter widths.
package uart_pkg;

    localparam int unsigned UartDataW = 8;
    localparam int unsigned IdleCntW  = 10;

    typedef struct packed {
        logic                 frame_err;
        logic [UartDataW-1:0] data;
    } uart_rx_entry_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO with flush and an explicit level counter.
// The caller only asserts push_i when there is room (or a pop happens in the same cycle).
module uart_fifo #(
    parameter int unsigned Width = 9,
    parameter int unsigned Depth = 16
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [Width-1:0]       wdata_i,
    output logic [Width-1:0]       rdata_o,
    output logic                   valid_o,
    output logic [$clog2(Depth):0] level_o,
    output logic [$clog2(Depth):0] level_nxt_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned LvlW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [LvlW-1:0]  level_q, level_d;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (push_i) wptr_d = wptr_q + PtrW'(1);
            if (pop_i)  rptr_d = rptr_q + PtrW'(1);
            level_d = level_q + LvlW'(push_i) - LvlW'(pop_i);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (push_i && !flush_i) mem_q[wptr_q] <= wdata_i;
    end

    assign valid_o     = (level_q != '0);
    // Gate the head so stale memory never shows while empty.
    assign rdata_o     = valid_o ? mem_q[rptr_q] : '0;
    assign level_o     = level_q;
    assign level_nxt_o = level_d;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: qualifies received characters into a FWFT FIFO, tracks
// overrun, runs the idle timeout and drives a registered level interrupt.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned TIMEOUT_BITS = 40
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic [15:0]            shift_div_i,
    input  logic                   enable_i,
    input  logic [7:0]             rx_data_i,
    input  logic                   rx_complete_i,
    input  logic                   rx_frame_err_i,
    input  logic                   rx_active_i,
    input  logic                   flush_i,
    input  logic                   rd_i,
    output logic [7:0]             rd_data_o,
    output logic                   rd_frame_err_o,
    output logic                   rd_valid_o,
    output logic [$clog2(DEPTH):0] level_o,
    input  logic [$clog2(DEPTH):0] thresh_i,
    output logic                   overrun_o,
    input  logic                   overrun_clr_i,
    output logic                   timeout_o,
    output logic                   irq_o
);

    localparam int unsigned LvlW = $clog2(DEPTH) + 1;

    logic            push_req, push_ok, pop_ok, drop, activity;
    logic [LvlW-1:0] level_nxt;
    uart_rx_entry_t  wr_entry, rd_entry;

    logic [15:0]         presc_q, presc_d;
    logic [IdleCntW-1:0] idle_q, idle_d;
    logic                timeout_q, timeout_d;
    logic                overrun_q, overrun_d;
    logic                irq_q, irq_d;
    logic                wrap;

    assign push_req = rx_complete_i & enable_i & ~flush_i;
    assign pop_ok   = rd_i & rd_valid_o & ~flush_i;
    // level never exceeds DEPTH, so "not full" is level < DEPTH.
    assign push_ok  = push_req & ((level_o != LvlW'(DEPTH)) | pop_ok);
    assign drop     = push_req & ~push_ok;
    assign activity = push_ok | pop_ok | flush_i;

    assign wr_entry.frame_err = rx_frame_err_i;
    assign wr_entry.data      = rx_data_i;

    uart_fifo #(
        .Width($bits(uart_rx_entry_t)),
        .Depth(DEPTH)
    ) u_fifo (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .flush_i    (flush_i),
        .push_i     (push_ok),
        .pop_i      (pop_ok),
        .wdata_i    (wr_entry),
        .rdata_o    (rd_entry),
        .valid_o    (rd_valid_o),
        .level_o    (level_o),
        .level_nxt_o(level_nxt)
    );

    assign rd_data_o      = rd_entry.data;
    assign rd_frame_err_o = rd_entry.frame_err;

    always_comb begin
        presc_d   = presc_q + 16'd1;
        idle_d    = idle_q;
        timeout_d = timeout_q;
        // >= so a divider lowered below the current count still wraps promptly.
        wrap      = (presc_q >= shift_div_i);
        if (activity) timeout_d = 1'b0;
        if (activity || rx_active_i) begin
            presc_d = '0;
            idle_d  = '0;
        end else begin
            if (wrap) presc_d = '0;
            if (wrap && (level_o != '0) && (idle_q < IdleCntW'(TIMEOUT_BITS))) begin
                idle_d = idle_q + IdleCntW'(1);
                if (idle_d == IdleCntW'(TIMEOUT_BITS)) timeout_d = 1'b1;
            end
        end
    end

    always_comb begin
        overrun_d = (overrun_q & ~overrun_clr_i) | drop;
        irq_d     = overrun_d | timeout_d |
                    ((thresh_i != '0) && (level_nxt >= thresh_i));
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            presc_q   <= '0;
            idle_q    <= '0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
            irq_q     <= irq_d;
        end
    end

    assign overrun_o = overrun_q;
    assign timeout_o = timeout_q;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_uart_rx_ctrl;

    localparam int unsigned DEPTH        = 16;
    localparam int unsigned TIMEOUT_BITS = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] shift_div;
    logic        enable, rx_complete, rx_fe, rx_active, flush, rd, ovr_clr;
    logic [7:0]  rx_data;
    logic [4:0]  thresh;
    logic [7:0]  rd_data;
    logic        rd_fe, rd_valid, overrun, timeout, irq;
    logic [4:0]  level;

    int errors = 0;
    int checks = 0;

    uart_rx_ctrl #(
        .DEPTH       (DEPTH),
        .TIMEOUT_BITS(TIMEOUT_BITS)
    ) dut (
        .clock_i       (clk),
        .reset_i       (rst),
        .shift_div_i   (shift_div),
        .enable_i      (enable),
        .rx_data_i     (rx_data),
        .rx_complete_i (rx_complete),
        .rx_frame_err_i(rx_fe),
        .rx_active_i   (rx_active),
        .flush_i       (flush),
        .rd_i          (rd),
        .rd_data_o     (rd_data),
        .rd_frame_err_o(rd_fe),
        .rd_valid_o    (rd_valid),
        .level_o       (level),
        .thresh_i      (thresh),
        .overrun_o     (overrun),
        .overrun_clr_i (ovr_clr),
        .timeout_o     (timeout),
        .irq_o         (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO contents as a queue, timeout as clocks since last event.
    logic [8:0] mq[$];
    logic       m_ovr, m_to, live = 1'b0;
    int         m_cnt;
    logic       m_push_req, m_pop, m_push_ok;
    logic [8:0] m_head;

    function automatic int limit();
        return TIMEOUT_BITS * (int'(shift_div) + 1);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_ovr = 1'b0;
            m_to  = 1'b0;
            m_cnt = 0;
            live  = 1'b1;
        end else if (live) begin
            m_push_req = rx_complete && enable && !flush;
            m_pop      = rd && (mq.size() != 0) && !flush;
            m_push_ok  = m_push_req && ((mq.size() < DEPTH) || m_pop);
            if (flush) mq.delete();
            else begin
                if (m_pop) void'(mq.pop_front());
                if (m_push_ok) mq.push_back({rx_fe, rx_data});
            end
            if (m_push_req && !m_push_ok) m_ovr = 1'b1;
            else if (ovr_clr) m_ovr = 1'b0;
            if (m_push_ok || m_pop || flush) m_to = 1'b0;
            if (m_push_ok || m_pop || flush || rx_active) m_cnt = 0;
            else if (mq.size() != 0) m_cnt++;
            if (m_cnt >= limit()) m_to = 1'b1;
        end
    end

    function automatic logic m_irq();
        return m_ovr || m_to || ((thresh != 0) && (mq.size() >= int'(thresh)));
    endfunction

    always @(negedge clk) begin
        if (live) begin
            m_head = (mq.size() != 0) ? mq[0] : 9'h0;
            chk("cyc_level",   int'(level),    mq.size());
            chk("cyc_valid",   int'(rd_valid), int'(mq.size() != 0));
            chk("cyc_data",    int'(rd_data),  int'(m_head[7:0]));
            chk("cyc_fe",      int'(rd_fe),    int'(m_head[8]));
            chk("cyc_overrun", int'(overrun),  int'(m_ovr));
            // One-clock tolerance on the timeout edge.
            if (!(m_cnt == limit() - 1 || m_cnt == limit())) begin
                chk("cyc_timeout", int'(timeout), int'(m_to));
                chk("cyc_irq",     int'(irq),     int'(m_irq()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic fe);
        rx_data = d; rx_fe = fe; rx_complete = 1'b1;
        tick();
        rx_complete = 1'b0; rx_fe = 1'b0;
    endtask

    task automatic pop();
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; shift_div = 16'd3; enable = 1'b1; rx_complete = 1'b0; rx_fe = 1'b0;
        rx_active = 1'b0; flush = 1'b0; rd = 1'b0; ovr_clr = 1'b0; rx_data = 8'h0;
        thresh = 5'd0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_level", int'(level), 0);
        chk("rst_valid", int'(rd_valid), 0);
        chk("rst_data", int'(rd_data), 0);
        chk("rst_irq", int'(irq), 0);
        chk("rst_overrun", int'(overrun), 0);
        tick();

        // Three characters with threshold 2.
        thresh = 5'd2;
        push(8'h41, 1'b0);
        chk("t1_level1", int'(level), 1);
        chk("t1_irq1", int'(irq), 0);
        push(8'h42, 1'b0);
        chk("t1_level2", int'(level), 2);
        chk("t1_irq2", int'(irq), 1);
        push(8'h43, 1'b0);
        chk("t1_level3", int'(level), 3);
        chk("t1_head0", int'(rd_data), 'h41);
        pop();
        chk("t1_head1", int'(rd_data), 'h42);
        chk("t1_irq_l2", int'(irq), 1);
        pop();
        chk("t1_head2", int'(rd_data), 'h43);
        chk("t1_irq_l1", int'(irq), 0);
        pop();
        chk("t1_empty", int'(rd_valid), 0);
        thresh = 5'd0;

        // Fill, overflow, simultaneous pop, disabled receive, clear-vs-set.
        for (int i = 0; i < 16; i++) push(8'(i), 1'b0);
        chk("t2_full", int'(level), 16);
        push(8'h55, 1'b0);
        chk("t2_ovr", int'(overrun), 1);
        chk("t2_ovr_level", int'(level), 16);
        chk("t2_ovr_irq", int'(irq), 1);
        chk("t2_ovr_head", int'(rd_data), 'h00);
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
        chk("t2_clr", int'(overrun), 0);
        rd = 1'b1; push(8'h55, 1'b0); rd = 1'b0;
        chk("t2_pp_level", int'(level), 16);
        chk("t2_pp_ovr", int'(overrun), 0);
        chk("t2_pp_head", int'(rd_data), 'h01);
        enable = 1'b0; push(8'h66, 1'b0); enable = 1'b1;
        chk("t6_dis_ovr", int'(overrun), 0);
        chk("t6_dis_level", int'(level), 16);
        ovr_clr = 1'b1; push(8'h77, 1'b0); ovr_clr = 1'b0;
        chk("t6_setwins", int'(overrun), 1);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("t2_flush_level", int'(level), 0);
        chk("t2_flush_ovr", int'(overrun), 1);
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;

        // Framing-error flag travels with its entry.
        push(8'h00, 1'b1);
        push(8'h7e, 1'b0);
        chk("t3_fe_head", int'(rd_fe), 1);
        chk("t3_fe_data", int'(rd_data), 'h00);
        pop();
        chk("t3_fe_next", int'(rd_fe), 0);
        chk("t3_data_next", int'(rd_data), 'h7e);
        pop();

        // Idle timeout: 40 bit-times of 4 clocks.
        push(8'hab, 1'b0);
        n = 0;
        while (!timeout && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (n < 159 || n > 161) begin
            errors++;
            $display("FAIL t4_timeout_clocks: got %0d, expected 160 +/- 1", n);
        end
        chk("t4_irq", int'(irq), 1);
        pop();
        chk("t4_to_clr", int'(timeout), 0);
        chk("t4_irq_clr", int'(irq), 0);

        // Flush wins over simultaneous push and pop.
        for (int i = 1; i <= 5; i++) push(8'(i), 1'b0);
        chk("t5_level5", int'(level), 5);
        flush = 1'b1; rd = 1'b1; push(8'hee, 1'b0); flush = 1'b0; rd = 1'b0;
        chk("t5_level", int'(level), 0);
        chk("t5_valid", int'(rd_valid), 0);
        chk("t5_ovr", int'(overrun), 0);
        push(8'h99, 1'b0);
        chk("t5_after", int'(rd_data), 'h99);
        chk("t5_after_level", int'(level), 1);
        pop();

        // rx_active holds off the timeout.
        push(8'h12, 1'b0);
        rx_active = 1'b1;
        repeat (200) tick();
        chk("t7_active_to", int'(timeout), 0);
        rx_active = 1'b0;
        pop();
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
